// File: rtl/serial_word_tx_pkg.sv
// Shared types and default constants for the serial word transmitter.
package serial_word_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  localparam int   MAX_BITS_DEF   = 320;
  localparam logic IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/serial_word_tx_if.sv
// Load handshake and serial line bundle between a word producer and serial_word_tx.
interface serial_word_tx_if
  import serial_word_tx_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEF,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
);

  logic                LoadValid;
  logic                LoadReady;
  logic [MAX_BITS-1:0] LoadData;
  logic [LEN_W-1:0]    LoadLen;
  logic                TXData;
  logic                TXBusy;
  logic                TXLast;

  modport master (
    output LoadValid, LoadData, LoadLen,
    input  LoadReady, TXData, TXBusy, TXLast
  );

  modport slave (
    input  LoadValid, LoadData, LoadLen,
    output LoadReady, TXData, TXBusy, TXLast
  );

endinterface

// File: rtl/serial_word_tx.sv
// LSB-first parallel-to-serial word transmitter with zero-gap back-to-back words.
// Optional start bit before each word: define SERIAL_WORD_TX_START_BIT_EN.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int   MAX_BITS   = MAX_BITS_DEF,
  parameter int   LEN_W      = $clog2(MAX_BITS + 1),
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              TXClk,
  input  logic              TXResetN,
  serial_word_tx_if.slave   bus
);

  tx_state_t           state_q, state_d;
  logic [MAX_BITS-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                txd_q, txd_d;
  logic                last_bit;
  logic                accept;
  logic [LEN_W-1:0]    len_eff;

  // cnt_q is the index of the bit currently on TXData; len_q is never 0 in SHIFT.
  assign last_bit       = (state_q == SHIFT) && (cnt_q == len_q - LEN_W'(1));
  assign bus.LoadReady  = (state_q == IDLE) || last_bit;
  assign accept         = bus.LoadValid && bus.LoadReady;
  assign len_eff        = (bus.LoadLen > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : bus.LoadLen;

  assign bus.TXData = txd_q;
  assign bus.TXBusy = (state_q != IDLE);
  assign bus.TXLast = last_bit;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    txd_d   = txd_q;

    case (state_q)
      START: begin
        state_d = SHIFT;
        txd_d   = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (!last_bit) begin
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + LEN_W'(1);
        end else begin
          state_d = IDLE;
          txd_d   = IDLE_LEVEL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = IDLE_LEVEL;
      end
    endcase

    // A new word overrides the return to IDLE, giving the zero-gap hand-over.
    if (accept) begin
      if (len_eff == '0) begin
        state_d = IDLE;
        txd_d   = IDLE_LEVEL;
        cnt_d   = '0;
      end else begin
        len_d = len_eff;
        cnt_d = '0;
`ifdef SERIAL_WORD_TX_START_BIT_EN
        state_d = START;
        txd_d   = ~IDLE_LEVEL;
        shreg_d = bus.LoadData;
`else
        state_d = SHIFT;
        txd_d   = bus.LoadData[0];
        shreg_d = bus.LoadData >> 1;
`endif
      end
    end
  end

  always_ff @(posedge TXClk or negedge TXResetN) begin
    if (!TXResetN) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      txd_q   <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      txd_q   <= txd_d;
    end
  end

endmodule
